// File: rtl/cdb_writeback.sv
// CDB arbiter + Qi tracker: three one-entry FU buffers, round-robin broadcast one edge after accept,
// register write one cycle later. Backpressure: x_ready low only while buffer x is full and not granted.
module cdb_writeback #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3,
    parameter int NREG   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic                     add_valid,
    input  logic [TAG_W-1:0]         add_tag,
    input  logic [DATA_W-1:0]        add_data,
    output logic                     add_ready,
    input  logic                     mul_valid,
    input  logic [TAG_W-1:0]         mul_tag,
    input  logic [DATA_W-1:0]        mul_data,
    output logic                     mul_ready,
    input  logic                     ld_valid,
    input  logic [TAG_W-1:0]         ld_tag,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [DATA_W-1:0]        dataIn,
    output logic [$clog2(NREG)-1:0]  dataAddress,
    output logic                     writeEnable,
    output logic [NREG-1:0]          reg_busy
);
    localparam int AW  = $clog2(NREG);
    localparam int NFU = 3;

    logic [NFU-1:0]             fu_vld, fu_rdy, fu_acc;
    logic [NFU-1:0][TAG_W-1:0]  fu_tag;
    logic [NFU-1:0][DATA_W-1:0] fu_dat;

    logic [NFU-1:0]             full_q, full_d;
    logic [NFU-1:0][TAG_W-1:0]  btag_q, btag_d;
    logic [NFU-1:0][DATA_W-1:0] bdat_q, bdat_d;
    logic [1:0]                 ptr_q, ptr_d;
    logic                       cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]           cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]          cdb_data_q, cdb_data_d;
    logic [NREG-1:0][TAG_W-1:0] qi_q, qi_d;

    logic [NFU-1:0]             gnt;
    logic [1:0]                 gnt_idx;
    logic                       gnt_any;
    logic [2:0]                 cand;
    logic [NREG-1:0]            match;
    logic                       issue_hit;

    // Unit index 0 = add, 1 = mul, 2 = ld
    assign fu_vld = {ld_valid, mul_valid, add_valid};
    assign fu_tag = {ld_tag, mul_tag, add_tag};
    assign fu_dat = {ld_data, mul_data, add_data};

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NFU; k++) begin
            cand = 3'(ptr_q) + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_any && full_q[cand[1:0]]) begin
                gnt_any           = 1'b1;
                gnt_idx           = cand[1:0];
                gnt[cand[1:0]]    = 1'b1;
            end
        end
    end

    assign fu_rdy = ~full_q | gnt;
    assign fu_acc = fu_vld & fu_rdy;

    // Tag-0 results complete the handshake but never occupy the buffer.
    always_comb begin
        full_d = '0;
        btag_d = btag_q;
        bdat_d = bdat_q;
        for (int i = 0; i < NFU; i++) begin
            full_d[i] = (full_q[i] & ~gnt[i]) | (fu_acc[i] & (fu_tag[i] != '0));
            if (fu_acc[i]) begin
                btag_d[i] = fu_tag[i];
                bdat_d[i] = fu_dat[i];
            end
        end
        ptr_d       = gnt_any ? ((gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1) : ptr_q;
        cdb_valid_d = gnt_any;
        cdb_tag_d   = gnt_any ? btag_q[gnt_idx] : cdb_tag_q;
        cdb_data_d  = gnt_any ? bdat_q[gnt_idx] : cdb_data_q;
    end

    // A same-cycle issue to r makes the broadcast stale for r: issue wins, write suppressed.
    always_comb begin
        qi_d        = qi_q;
        match       = '0;
        issue_hit   = 1'b0;
        writeEnable = 1'b0;
        dataAddress = '0;
        dataIn      = cdb_data_q;
        reg_busy    = '0;
        for (int r = 1; r < NREG; r++) begin
            issue_hit = issue_valid && (issue_rd == AW'(r));
            match[r]  = cdb_valid_q && (cdb_tag_q != '0) && (qi_q[r] == cdb_tag_q) && !issue_hit;
            if (issue_hit)     qi_d[r] = issue_tag;
            else if (match[r]) qi_d[r] = '0;
            reg_busy[r] = (qi_q[r] != '0);
        end
        for (int r = NREG - 1; r >= 1; r--) begin
            if (match[r]) begin
                writeEnable = 1'b1;
                dataAddress = AW'(r);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q      <= '0;
            btag_q      <= '0;
            bdat_q      <= '0;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            qi_q        <= '0;
        end else begin
            full_q      <= full_d;
            btag_q      <= btag_d;
            bdat_q      <= bdat_d;
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            qi_q        <= qi_d;
        end
    end

    assign add_ready = fu_rdy[0];
    assign mul_ready = fu_rdy[1];
    assign ld_ready  = fu_rdy[2];
    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
endmodule
